// File: rtl/logic_accum_pkg.sv
// Shared types for the bitwise logic accumulator: operation codes and FSM states.
package logic_accum_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/logic_op.sv
// Combinational op unit: single-beat result, base-op reduction of the operands,
// and the running accumulator folded with that reduction.
module logic_op
    import logic_accum_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] beat,
    output logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] acc_next
);

    // NAND bursts accumulate with AND; the final inversion happens in the top.
    always_comb begin
        beat     = '0;
        base     = '0;
        acc_next = '0;
        case (op_e'(op))
            OP_AND: begin
                base     = a & b;
                beat     = base;
                acc_next = acc & base;
            end
            OP_OR: begin
                base     = a | b;
                beat     = base;
                acc_next = acc | base;
            end
            OP_XOR: begin
                base     = a ^ b;
                beat     = base;
                acc_next = acc ^ base;
            end
            OP_NAND: begin
                base     = a & b;
                beat     = ~base;
                acc_next = acc & base;
            end
            default: begin
                base     = '0;
                beat     = '0;
                acc_next = '0;
            end
        endcase
    end

endmodule

// File: rtl/logic_accum.sv
// Bitwise logic accumulator: per-item or burst-accumulated AND/OR/XOR/NAND
// with valid/ready handshakes on both sides.
//
//  state   | meaning
//  S_IDLE  | waiting for first beat of an item or burst
//  S_ACCUM | burst open, folding further beats into acc with the latched op
//  S_HOLD  | result presented, waiting for out_ready
module logic_accum
    import logic_accum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q;
    state_e           state_d;
    op_e              op_q;
    op_e              op_sel;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] beat;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] y_d;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;

    assign accept = in_valid && in_ready;
    assign op_sel = (state_q == S_ACCUM) ? op_q : op_e'(in_op);

    logic_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .a        (in_a),
        .b        (in_b),
        .acc      (acc_q),
        .op       (op_sel),
        .beat     (beat),
        .base     (base),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (!in_mode || in_last) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept && in_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != S_HOLD);
        out_valid = (state_q == S_HOLD);
    end

    // A first beat's result equals the single-beat value in either mode.
    always_comb begin
        y_d   = beat;
        cnt_d = CNT_ONE;
        if (state_q == S_ACCUM) begin
            y_d   = (op_q == OP_NAND) ? ~acc_next : acc_next;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            op_q   <= OP_AND;
            y_q    <= '0;
            zero_q <= 1'b1;
            cnt_q  <= '0;
        end else if (accept) begin
            if (state_q == S_IDLE) begin
                acc_q <= base;
                op_q  <= op_e'(in_op);
            end else begin
                acc_q <= acc_next;
            end
            y_q    <= y_d;
            zero_q <= (y_d == '0);
            cnt_q  <= cnt_d;
        end
    end

    assign out_y     = y_q;
    assign out_zero  = zero_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_logic_accum.sv
// Self-checking bench for logic_accum: directed literal cases plus a randomized
// phase, all compared each cycle against a behavioural operand-folding model.
module tb_logic_accum;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [1:0]       in_op = '0;
    logic             in_mode = 1'b0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic [CNT_W-1:0] out_count;

    int total = 0;
    int bad   = 0;

    logic_accum #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: fold every operand of the item/burst with the burst's op.
    bit               m_hold  = 0;
    bit               m_burst = 0;
    logic [1:0]       m_op    = '0;
    logic [WIDTH-1:0] m_and, m_or, m_xor;
    logic [WIDTH-1:0] m_y     = '0;
    int               m_n     = 0;
    int               m_cnt   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold  = 0;
            m_burst = 0;
            m_n     = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 0;
        end else if (in_valid) begin
            if (!m_burst) begin
                m_op  = in_op;
                m_and = '1;
                m_or  = '0;
                m_xor = '0;
                m_n   = 0;
            end
            m_and = m_and & in_a & in_b;
            m_or  = m_or | in_a | in_b;
            m_xor = m_xor ^ in_a ^ in_b;
            m_n++;
            if ((!m_burst && !in_mode) || in_last) begin
                case (m_op)
                    2'd0:    m_y = m_and;
                    2'd1:    m_y = m_or;
                    2'd2:    m_y = m_xor;
                    default: m_y = ~m_and;
                endcase
                m_cnt   = (m_n > CMAX) ? CMAX : m_n;
                m_burst = 0;
                m_hold  = 1;
            end else begin
                m_burst = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, !m_hold);
            chk("out_valid", out_valid, m_hold);
            if (m_hold) begin
                chk("out_y", out_y, m_y);
                chk("out_zero", out_zero, (m_y == '0));
                chk("out_count", out_count, m_cnt);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic mode, input logic last);
        int g = 0;
        in_a = a; in_b = b; in_op = op; in_mode = mode; in_last = last;
        in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stuck low");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take();
        int g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            total++; bad++;
            $display("FAIL take_timeout: out_valid stuck low");
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic expect_res(input string nm, input logic [7:0] y, input int cnt);
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_y"}, out_y, y);
        chk({nm, "_count"}, out_count, cnt);
        chk({nm, "_zero"}, out_zero, (y == 8'h00));
        chk({nm, "_model"}, m_y, y);
        take();
    endtask

    initial begin
        #23;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_y", out_y, 8'h00);
        chk("rst_zero", out_zero, 1'b1);
        chk("rst_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", in_ready, 1'b1);

        // per-item
        send(8'hF0, 8'h3C, 2'd0, 1'b0, 1'b0);
        expect_res("item_and", 8'h30, 1);
        send(8'hAA, 8'h0F, 2'd0, 1'b0, 1'b0);
        expect_res("op_and", 8'h0A, 1);
        send(8'hAA, 8'h0F, 2'd1, 1'b0, 1'b1);
        expect_res("op_or", 8'hAF, 1);
        send(8'hAA, 8'h0F, 2'd2, 1'b0, 1'b0);
        expect_res("op_xor", 8'hA5, 1);
        send(8'hAA, 8'h0F, 2'd3, 1'b0, 1'b0);
        expect_res("op_nand", 8'hF5, 1);
        send(8'hF0, 8'h0F, 2'd0, 1'b0, 1'b0);
        expect_res("zero_item", 8'h00, 1);

        // single-beat burst matches per-item
        send(8'hAA, 8'h0F, 2'd3, 1'b1, 1'b1);
        expect_res("single_burst", 8'hF5, 1);

        // bursts; later op/mode changes must be ignored
        send(8'hFF, 8'hF7, 2'd0, 1'b1, 1'b0);
        send(8'h7F, 8'hFF, 2'd2, 1'b0, 1'b0);
        send(8'hFE, 8'hFF, 2'd1, 1'b0, 1'b1);
        expect_res("acc_and", 8'h76, 3);

        send(8'h01, 8'h02, 2'd2, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("accum_idle_valid", out_valid, 1'b0);
        send(8'h04, 8'h08, 2'd0, 1'b1, 1'b0);
        send(8'h10, 8'h20, 2'd2, 1'b1, 1'b1);
        expect_res("acc_xor", 8'h3F, 3);

        send(8'hFF, 8'hFF, 2'd3, 1'b1, 1'b0);
        send(8'h00, 8'hFF, 2'd3, 1'b1, 1'b1);
        expect_res("acc_nand", 8'hFF, 2);

        // count saturates, acc keeps folding
        for (int i = 0; i < 16; i++) send(8'hFF, 8'hFF, 2'd0, 1'b1, 1'b0);
        send(8'hFE, 8'hFF, 2'd0, 1'b1, 1'b0);
        send(8'hFF, 8'h7F, 2'd0, 1'b1, 1'b1);
        expect_res("acc_sat", 8'h7E, CMAX);

        // backpressure with a beat on offer
        send(8'h5A, 8'h0F, 2'd1, 1'b0, 1'b0);
        in_a = 8'h11; in_b = 8'h22; in_op = 2'd2; in_mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_y", out_y, 8'h5F);
            chk("bp_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // reset mid-burst
        send(8'hFF, 8'h0F, 2'd1, 1'b1, 1'b0);
        send(8'h30, 8'h01, 2'd1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_zero", out_zero, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", out_valid, 1'b0);
        send(8'h5A, 8'hFF, 2'd2, 1'b0, 1'b0);
        expect_res("post_rst_item", 8'hA5, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_op     = 2'($urandom_range(0, 3));
            in_mode   = ($urandom_range(0, 2) != 0);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
